// File: rtl/ebus_arbiter.sv
// EBUS ownership arbiter: round-robin grant, DEMAND/XFER handshake sequencing,
// DEMAND timeout and multiple-driver conflict detection on the mux select lines.
module ebus_arbiter #(
   parameter int NREQ    = 4,
   parameter int NDRV    = 12,
   parameter int TIMEOUT = 64
) (
   input  logic                    clk,
   input  logic                    CROBAR_N,
   input  logic [NREQ-1:0]         REQ,
   input  logic                    XFER,
   input  logic [NDRV-1:0]         DRIVING,
   input  logic                    ERR_CLR,
   output logic [NREQ-1:0]         GRANT,
   output logic                    DEMAND,
   output logic                    DONE,
   output logic                    TIMEOUT_ERR,
   output logic                    CONFLICT,
   output logic [$clog2(NREQ)-1:0] OWNER
);

   localparam int OW = $clog2(NREQ);
   localparam int CW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {IDLE_S, GRANT_S, DEMAND_S, HOLD_S} stateT;

   stateT         state;
   stateT         stateNext;
   logic [OW-1:0] ownerReg;
   logic [OW-1:0] ownerNext;
   logic [OW-1:0] idx;
   logic [CW-1:0] count;
   logic [CW-1:0] countNext;
   logic          doneNext;
   logic          timeoutHit;
   logic          found;

   // Sticky error flags: a new error in the same cycle as ERR_CLR keeps the flag set.
   always_ff @(posedge clk or negedge CROBAR_N) begin
      if (!CROBAR_N) begin
         state       <= IDLE_S;
         ownerReg    <= OW'(NREQ - 1);
         count       <= '0;
         DONE        <= 1'b0;
         TIMEOUT_ERR <= 1'b0;
         CONFLICT    <= 1'b0;
      end else begin
         state       <= stateNext;
         ownerReg    <= ownerNext;
         count       <= countNext;
         DONE        <= doneNext;
         TIMEOUT_ERR <= timeoutHit | (TIMEOUT_ERR & ~ERR_CLR);
         CONFLICT    <= ($countones(DRIVING) > 1) | (CONFLICT & ~ERR_CLR);
      end
   end

   // Round-robin search starts one past the last owner, so reset (owner=NREQ-1) starts at 0.
   always_comb begin
      stateNext  = state;
      ownerNext  = ownerReg;
      countNext  = count;
      doneNext   = 1'b0;
      timeoutHit = 1'b0;
      found      = 1'b0;
      idx        = '0;
      case (state)
         IDLE_S: begin
            for (int i = 1; i <= NREQ; i++) begin
               idx = OW'((int'(ownerReg) + i) % NREQ);
               if (!found && REQ[idx]) begin
                  ownerNext = idx;
                  found     = 1'b1;
               end
            end
            if (found) stateNext = GRANT_S;
         end
         GRANT_S: begin
            if (!REQ[ownerReg]) begin
               stateNext = IDLE_S;
            end else begin
               stateNext = DEMAND_S;
               countNext = '0;
            end
         end
         DEMAND_S: begin
            countNext = count + CW'(1);
            if (XFER) begin
               stateNext = HOLD_S;
               doneNext  = 1'b1;
            end else if (!REQ[ownerReg]) begin
               stateNext = IDLE_S;
            end else if (count == CW'(TIMEOUT - 1)) begin
               stateNext  = IDLE_S;
               timeoutHit = 1'b1;
            end
         end
         HOLD_S: begin
            if (!REQ[ownerReg]) stateNext = IDLE_S;
         end
         default: stateNext = IDLE_S;
      endcase
   end

   // Outputs decode registered state only, so nothing flows combinationally from inputs.
   always_comb begin
      GRANT = '0;
      if (state != IDLE_S) GRANT[ownerReg] = 1'b1;
      DEMAND = (state == DEMAND_S);
      OWNER  = ownerReg;
   end

endmodule

// File: tb/tb_ebus_arbiter.sv
// Self-checking bench for ebus_arbiter: a tenure-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_ebus_arbiter;

   localparam int NREQ    = 4;
   localparam int NDRV    = 12;
   localparam int TIMEOUT = 8;

   logic            clk = 1'b0;
   logic            CROBAR_N;
   logic [3:0]      REQ;
   logic            XFER;
   logic [11:0]     DRIVING;
   logic            ERR_CLR;
   logic [3:0]      GRANT;
   logic            DEMAND;
   logic            DONE;
   logic            TIMEOUT_ERR;
   logic            CONFLICT;
   logic [1:0]      OWNER;

   int compared   = 0;
   int mismatched = 0;
   logic checkEn  = 1'b0;

   logic busyM, settleM, heldM, hitM, eDone, eTerr, eConf;
   int   dcountM, ownerM, baseM;
   logic [3:0] expGrant;
   int   demandCycles;
   int   order [5] = '{0, 1, 2, 3, 0};

   ebus_arbiter #(.NREQ(NREQ), .NDRV(NDRV), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .CROBAR_N(CROBAR_N), .REQ(REQ), .XFER(XFER), .DRIVING(DRIVING),
      .ERR_CLR(ERR_CLR), .GRANT(GRANT), .DEMAND(DEMAND), .DONE(DONE),
      .TIMEOUT_ERR(TIMEOUT_ERR), .CONFLICT(CONFLICT), .OWNER(OWNER)
   );

   always #5 clk = ~clk;

   function automatic logic reqBit(input int k);
      return ((int'(REQ) >> k) & 1) == 1;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] req, input logic xfer, input logic [11:0] driving, input logic errClr);
      REQ     = req;
      XFER    = xfer;
      DRIVING = driving;
      ERR_CLR = errClr;
   endtask

   // Tenure-level model: busy/settle/held describe where the owner is in its transfer.
   always @(posedge clk or negedge CROBAR_N) begin
      if (!CROBAR_N) begin
         busyM = 1'b0; settleM = 1'b0; heldM = 1'b0; dcountM = 0; ownerM = NREQ - 1;
         eDone = 1'b0; eTerr = 1'b0; eConf = 1'b0;
      end else begin
         hitM  = 1'b0;
         eDone = 1'b0;
         if (!busyM) begin
            baseM = ownerM;
            for (int i = 1; i <= NREQ; i++) begin
               if (!busyM && reqBit((baseM + i) % NREQ)) begin
                  ownerM = (baseM + i) % NREQ;
                  busyM = 1'b1; settleM = 1'b1; heldM = 1'b0;
               end
            end
         end else if (settleM) begin
            if (!reqBit(ownerM)) busyM = 1'b0;
            else begin settleM = 1'b0; dcountM = 0; end
         end else if (!heldM) begin
            dcountM++;
            if (XFER) begin heldM = 1'b1; eDone = 1'b1; end
            else if (!reqBit(ownerM)) busyM = 1'b0;
            else if (dcountM == TIMEOUT) begin busyM = 1'b0; hitM = 1'b1; end
         end else if (!reqBit(ownerM)) begin
            busyM = 1'b0; heldM = 1'b0;
         end
         eTerr = hitM || (eTerr && !ERR_CLR);
         eConf = ($countones(DRIVING) > 1) || (eConf && !ERR_CLR);
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (checkEn) begin
         expGrant = 4'b0000;
         if (busyM) expGrant = 4'b0001 << ownerM;
         checkOutput("m_grant",   32'(GRANT),       32'(expGrant));
         checkOutput("m_demand",  32'(DEMAND),      32'(busyM && !settleM && !heldM));
         checkOutput("m_done",    32'(DONE),        32'(eDone));
         checkOutput("m_terr",    32'(TIMEOUT_ERR), 32'(eTerr));
         checkOutput("m_conf",    32'(CONFLICT),    32'(eConf));
         checkOutput("m_owner",   32'(OWNER),       32'(ownerM));
         checkOutput("m_onehot",  32'($onehot0(GRANT)), 32'(1));
      end
   end

   initial begin
      CROBAR_N = 1'b1;
      applyStimulus(4'b0000, 1'b0, 12'h000, 1'b0);
      #1 CROBAR_N = 1'b0;
      #21 CROBAR_N = 1'b1;
      @(negedge clk);
      checkEn = 1'b1;
      checkOutput("rst_grant", 32'(GRANT), 32'h0);
      checkOutput("rst_owner", 32'(OWNER), 32'h3);

      // Round-robin with all requesters held; each owner releases for one cycle.
      applyStimulus(4'b1111, 1'b0, 12'h000, 1'b0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checkOutput("rr_grant", 32'(GRANT), 32'(4'b0001 << order[k]));
         checkOutput("rr_settle", 32'(DEMAND), 32'h0);
         @(negedge clk);
         checkOutput("rr_demand", 32'(DEMAND), 32'h1);
         XFER = 1'b1;
         @(negedge clk);
         checkOutput("rr_done", 32'(DONE), 32'h1);
         XFER = 1'b0;
         REQ  = 4'b1111 & ~(4'b0001 << order[k]);
         @(negedge clk);
         checkOutput("rr_dead", 32'(GRANT), 32'h0);
         REQ = 4'b1111;
      end
      REQ = 4'b0000;
      @(negedge clk);

      // Single request, XFER after three DEMAND cycles.
      applyStimulus(4'b0001, 1'b0, 12'h000, 1'b0);
      @(negedge clk);
      checkOutput("one_grant", 32'(GRANT), 32'h1);
      checkOutput("one_nodemand", 32'(DEMAND), 32'h0);
      @(negedge clk);
      checkOutput("one_demand1", 32'(DEMAND), 32'h1);
      @(negedge clk);
      @(negedge clk);
      checkOutput("one_demand3", 32'(DEMAND), 32'h1);
      XFER = 1'b1;
      @(negedge clk);
      checkOutput("one_done", 32'(DONE), 32'h1);
      checkOutput("one_hold", 32'(DEMAND), 32'h0);
      XFER = 1'b0;
      @(negedge clk);
      checkOutput("one_done_once", 32'(DONE), 32'h0);
      checkOutput("one_hold_grant", 32'(GRANT), 32'h1);
      REQ = 4'b0000;
      @(negedge clk);
      checkOutput("one_release", 32'(GRANT), 32'h0);

      // Timeout with XFER never asserted.
      applyStimulus(4'b0010, 1'b0, 12'h000, 1'b0);
      @(negedge clk);
      checkOutput("to_grant", 32'(GRANT), 32'h2);
      demandCycles = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (DEMAND) demandCycles++;
         if (GRANT == 4'b0000) break;
      end
      checkOutput("to_demand_cycles", 32'(demandCycles), 32'd8);
      checkOutput("to_grant_off", 32'(GRANT), 32'h0);
      checkOutput("to_err", 32'(TIMEOUT_ERR), 32'h1);
      checkOutput("to_model_err", 32'(eTerr), 32'h1);
      applyStimulus(4'b0000, 1'b0, 12'h000, 1'b1);
      @(negedge clk);
      checkOutput("to_cleared", 32'(TIMEOUT_ERR), 32'h0);
      applyStimulus(4'b0010, 1'b0, 12'h000, 1'b0);
      @(negedge clk);
      repeat (8) @(negedge clk);
      ERR_CLR = 1'b1;
      @(negedge clk);
      checkOutput("to_clr_race", 32'(TIMEOUT_ERR), 32'h1);
      checkOutput("to_clr_grant", 32'(GRANT), 32'h0);
      applyStimulus(4'b0000, 1'b0, 12'h000, 1'b0);
      @(negedge clk);

      // Owner drops REQ during DEMAND: abort, no DONE.
      applyStimulus(4'b0100, 1'b0, 12'h000, 1'b0);
      @(negedge clk);
      checkOutput("ab_grant", 32'(GRANT), 32'h4);
      @(negedge clk);
      REQ = 4'b0000;
      @(negedge clk);
      checkOutput("ab_idle", 32'(GRANT), 32'h0);
      checkOutput("ab_nodone", 32'(DONE), 32'h0);

      // XFER and REQ drop together: XFER wins.
      applyStimulus(4'b1000, 1'b0, 12'h000, 1'b0);
      @(negedge clk);
      checkOutput("pri_grant", 32'(GRANT), 32'h8);
      @(negedge clk);
      applyStimulus(4'b0000, 1'b1, 12'h000, 1'b0);
      @(negedge clk);
      checkOutput("pri_done", 32'(DONE), 32'h1);
      checkOutput("pri_hold", 32'(GRANT), 32'h8);
      XFER = 1'b0;
      @(negedge clk);
      checkOutput("pri_release", 32'(GRANT), 32'h0);

      // Conflict detection, independent of the FSM.
      applyStimulus(4'b0000, 1'b0, 12'h000, 1'b1);
      @(negedge clk);
      applyStimulus(4'b0000, 1'b0, 12'h001, 1'b0);
      @(negedge clk);
      checkOutput("cf_single", 32'(CONFLICT), 32'h0);
      DRIVING = 12'h081;
      @(negedge clk);
      checkOutput("cf_set", 32'(CONFLICT), 32'h1);
      DRIVING = 12'h000;
      @(negedge clk);
      checkOutput("cf_sticky", 32'(CONFLICT), 32'h1);
      ERR_CLR = 1'b1;
      @(negedge clk);
      checkOutput("cf_clear", 32'(CONFLICT), 32'h0);
      ERR_CLR = 1'b0;

      // Asynchronous reset in the middle of DEMAND.
      applyStimulus(4'b0001, 1'b0, 12'h003, 1'b0);
      @(negedge clk);
      checkOutput("rs_grant", 32'(GRANT), 32'h1);
      @(negedge clk);
      checkOutput("rs_demand", 32'(DEMAND), 32'h1);
      checkOutput("rs_conf", 32'(CONFLICT), 32'h1);
      #2 CROBAR_N = 1'b0;
      #1;
      checkOutput("rs_async_grant", 32'(GRANT), 32'h0);
      checkOutput("rs_async_demand", 32'(DEMAND), 32'h0);
      checkOutput("rs_async_conf", 32'(CONFLICT), 32'h0);
      checkOutput("rs_async_terr", 32'(TIMEOUT_ERR), 32'h0);
      checkOutput("rs_async_owner", 32'(OWNER), 32'h3);
      applyStimulus(4'b0100, 1'b0, 12'h000, 1'b0);
      @(negedge clk);
      #2 CROBAR_N = 1'b1;
      @(negedge clk);
      checkOutput("rs_regrant", 32'(GRANT), 32'h4);
      checkOutput("rs_owner", 32'(OWNER), 32'h2);
      REQ = 4'b0000;
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/ebus_arbiter.md
# ebus_arbiter

EBUS ownership arbiter and transfer sequencer. It sits beside the top-level EBUS data mux and shares EBUS between the EBOX and the internal-channel/DTE controllers. It grants the bus to one requester at a time with round-robin fairness and runs the DEMAND/XFER handshake for each transfer. It enforces a transfer timeout and flags multiple-driver conflicts observed on the mux select lines.

## Interface
Parameters:
- NREQ, 4, number of EBUS requesters; index 0 is EBOX.
- NDRV, 12, number of EBUSdriver.driving lines monitored.
- TIMEOUT, 64, cycles allowed in DEMAND before forced abort; minimum 2.

Ports:
- clk  in  1  single system clock; all state changes on posedge.
- CROBAR_N  in  1  reset, asynchronous assert, active-low.
- REQ  in  NREQ  requester wants the bus; held high for the whole tenure, dropped to release.
- XFER  in  1  transfer acknowledge from the granted device.
- DRIVING  in  NDRV  per-module EBUSdriver.driving flags.
- ERR_CLR  in  1  clears the sticky error flags.
- GRANT  out  NREQ  one-hot (or zero) ownership.
- DEMAND  out  1  transfer strobe to the owner.
- DONE  out  1  one-cycle pulse on transfer completion.
- TIMEOUT_ERR  out  1  sticky; set on a DEMAND timeout.
- CONFLICT  out  1  sticky; set when more than one DRIVING bit is high.
- OWNER  out  $clog2(NREQ)  index of the current or last owner.

## Operation
- States: IDLE, GRANT, DEMAND, HOLD.
- IDLE: GRANT=0, DEMAND=0. If any REQ bit is set, pick the first set bit searching upward from OWNER+1 mod NREQ, wrapping around. Load OWNER, set GRANT[OWNER], go to GRANT.
- GRANT: one settle cycle.
  - If REQ[OWNER] is low, abort to IDLE with no DONE.
  - Otherwise go to DEMAND and clear the timeout counter.
- DEMAND: DEMAND=1; the counter increments each cycle.
  - XFER high: go to HOLD, pulse DONE, drop DEMAND.
  - REQ[OWNER] low (and no XFER): abort to IDLE with no DONE.
  - Counter reaches TIMEOUT-1 with no XFER: set TIMEOUT_ERR, clear GRANT, go to IDLE.
  - Priority when events coincide: XFER > REQ drop > timeout.
- HOLD: GRANT stays asserted and DEMAND=0. Move to IDLE when REQ[OWNER] goes low.
- GRANT is never multi-hot. Other REQ bits are ignored outside IDLE, so there is no preemption.
- CONFLICT is sampled every cycle: it sets when popcount(DRIVING) > 1. This is independent of the state machine.
- ERR_CLR clears both sticky flags. A new error in the same cycle as ERR_CLR wins, so the flag stays set.
- Reset values: state IDLE, GRANT=0, DEMAND=0, DONE=0, TIMEOUT_ERR=0, CONFLICT=0, OWNER=NREQ-1. With OWNER=NREQ-1, the first search starts at index 0.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- Grant latency:
  - Edge 1: REQ is high at this edge in IDLE; GRANT becomes visible after it.
  - Edge 2: DEMAND becomes visible after this edge.
- XFER sampled high at edge k: DONE=1 and DEMAND=0 for the cycle after k; DONE lasts exactly one cycle.
- Release:
  - REQ low sampled in HOLD returns the arbiter to IDLE with GRANT=0.
  - IDLE always lasts at least one cycle, giving a guaranteed dead cycle between owners.
- Timeout:
  - DEMAND asserted for exactly TIMEOUT cycles.
  - GRANT drops and TIMEOUT_ERR rises together on the following cycle.
- Reset asserted mid-transfer: all outputs go to reset values immediately, without waiting for clk.
- After reset is released, arbitration resumes on the first posedge that sees any REQ bit high.
- A single active requester that re-raises REQ after release is re-granted; the dead cycle still applies.

## Test plan
- Single request: REQ=0001, XFER after 3 DEMAND cycles -> GRANT=0001 at cycle 1, DEMAND cycles 2–4, DONE one pulse, GRANT=0 the cycle after REQ drops.
- Round-robin: REQ=1111 held, each owner completes and releases -> grant order 0,1,2,3,0 with exactly one idle cycle between grants; GRANT never multi-hot.
- Timeout: TIMEOUT=8, XFER never asserted -> DEMAND high exactly 8 cycles, then TIMEOUT_ERR=1 and GRANT=0; ERR_CLR clears it; ERR_CLR together with a new timeout leaves it at 1.
- Abort and priority:
  - REQ[owner] dropped in DEMAND -> IDLE, no DONE.
  - XFER and REQ drop in the same cycle -> DONE pulses.
- Conflict: DRIVING=0x001 -> CONFLICT stays 0; DRIVING=0x081 for one cycle -> CONFLICT=1 and remains set until ERR_CLR.
- Reset mid-DEMAND: CROBAR_N low between clock edges -> GRANT, DEMAND and flags go to 0 asynchronously; after release, REQ=0100 -> GRANT=0100.
